// File: rtl/console_uart_tx.sv
// Memory-mapped console transmitter: snoops byte writes to BASE_ADDR, queues them
// in a small FIFO and sends them out as 8N1 UART frames on txd.
module console_uart_tx #(
   parameter logic [15:0] BASE_ADDR = 16'hff00,
   parameter int unsigned DIV       = 4,
   parameter int unsigned DEPTH     = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] dwrite_addr,
   input  logic [15:0] dwrite_data,
   input  logic [1:0]  dwrite_en,
   input  logic [15:0] dread_addr,
   output logic [15:0] status_data,
   output logic        status_sel,
   output logic        txd,
   output logic        busy,
   output logic        overflow
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned DW = (DIV > 1) ? $clog2(DIV) : 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_DATA  = 2'd2;
   localparam logic [1:0] S_STOP  = 2'd3;

   logic [1:0]    r_state;
   logic [DW-1:0] r_div;
   logic [2:0]    r_bit;
   logic [7:0]    r_shift;
   logic          r_txd;
   logic          r_overflow;
   logic [CW-1:0] r_count;
   logic [PW-1:0] r_wptr;
   logic [PW-1:0] r_rptr;
   logic [7:0]    r_mem [DEPTH];

   logic          w_empty;
   logic          w_full;
   logic          w_div_last;
   logic          w_pop;
   logic          w_req_lo;
   logic          w_req_hi;
   logic          w_req;
   logic          w_push;
   logic          w_clr;
   logic [7:0]    w_push_byte;
   logic [7:0]    w_head;

   assign w_empty    = (r_count == '0);
   assign w_full     = (r_count == CW'(DEPTH));
   assign w_div_last = (r_div == DW'(DIV - 1));
   assign w_head     = r_mem[r_rptr];

   // Pop on an idle serialiser, or on the last STOP edge so frames run gapless.
   assign w_pop = !w_empty && ((r_state == S_IDLE) || ((r_state == S_STOP) && w_div_last));

   assign w_req_lo    = (dwrite_addr == BASE_ADDR) && dwrite_en[0];
   assign w_req_hi    = (dwrite_addr == (BASE_ADDR - 16'd1)) && dwrite_en[1];
   assign w_req       = w_req_lo || w_req_hi;
   assign w_push_byte = w_req_lo ? dwrite_data[7:0] : dwrite_data[15:8];
   assign w_push      = w_req && (!w_full || w_pop);

   assign w_clr = ((dwrite_addr == (BASE_ADDR + 16'd1)) && dwrite_en[0] && dwrite_data[0]) ||
                  ((dwrite_addr == BASE_ADDR) && dwrite_en[1] && dwrite_data[8]);

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wptr] <= w_push_byte;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_count    <= '0;
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + PW'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + PW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
         // A dropped push outranks a clear on the same edge.
         if (w_req && !w_push) begin
            r_overflow <= 1'b1;
         end else if (w_clr) begin
            r_overflow <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_div   <= '0;
         r_bit   <= '0;
         r_shift <= '0;
         r_txd   <= 1'b1;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_pop) begin
                  r_state <= S_START;
                  r_shift <= w_head;
                  r_div   <= '0;
                  r_txd   <= 1'b0;
               end
            end
            S_START: begin
               if (w_div_last) begin
                  r_state <= S_DATA;
                  r_div   <= '0;
                  r_bit   <= '0;
                  r_txd   <= r_shift[0];
                  r_shift <= {1'b0, r_shift[7:1]};
               end else begin
                  r_div <= r_div + DW'(1);
               end
            end
            S_DATA: begin
               if (w_div_last) begin
                  r_div <= '0;
                  if (r_bit == 3'd7) begin
                     r_state <= S_STOP;
                     r_txd   <= 1'b1;
                  end else begin
                     r_bit   <= r_bit + 3'd1;
                     r_txd   <= r_shift[0];
                     r_shift <= {1'b0, r_shift[7:1]};
                  end
               end else begin
                  r_div <= r_div + DW'(1);
               end
            end
            S_STOP: begin
               if (w_div_last) begin
                  r_div <= '0;
                  if (w_pop) begin
                     r_state <= S_START;
                     r_shift <= w_head;
                     r_txd   <= 1'b0;
                  end else begin
                     r_state <= S_IDLE;
                     r_txd   <= 1'b1;
                  end
               end else begin
                  r_div <= r_div + DW'(1);
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_div   <= '0;
               r_txd   <= 1'b1;
            end
         endcase
      end
   end

   assign txd      = r_txd;
   assign overflow = r_overflow;
   assign busy     = !w_empty || (r_state != S_IDLE);

   // BASE_ADDR is even, so forcing bit 0 on both sides compares address bits [15:1].
   assign status_sel = ((dread_addr | 16'h0001) == (BASE_ADDR | 16'h0001));

   always_comb begin
      status_data = '0;
      if (status_sel) begin
         status_data[0]    = w_full;
         status_data[1]    = w_empty;
         status_data[2]    = busy;
         status_data[3]    = r_overflow;
         status_data[11:8] = 4'(r_count);
      end
   end

endmodule

// File: tb/tb_console_uart_tx.sv
// Directed bench for console_uart_tx: checks status, exact txd waveforms,
// FIFO overflow handling and reset abort.
module tb_console_uart_tx;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] dwrite_addr;
   logic [15:0] dwrite_data;
   logic [1:0]  dwrite_en;
   logic [15:0] dread_addr;
   logic [15:0] status_data;
   logic        status_sel;
   logic        txd;
   logic        busy;
   logic        overflow;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0] burst [10] = '{8'h31, 8'hA5, 8'h00, 8'hFF, 8'h5A, 8'hC3, 8'h7E, 8'h81, 8'h18, 8'h99};

   console_uart_tx #(
      .BASE_ADDR(16'hff00),
      .DIV(4),
      .DEPTH(8)
   ) u_dut (
      .clk(clk),
      .reset(reset),
      .dwrite_addr(dwrite_addr),
      .dwrite_data(dwrite_data),
      .dwrite_en(dwrite_en),
      .dread_addr(dread_addr),
      .status_data(status_data),
      .status_sel(status_sel),
      .txd(txd),
      .busy(busy),
      .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Called just after the push/pop edge E; checks txd after edges E+1..E+40.
   task automatic check_frame(input logic [7:0] b, input string tag);
      logic exp;
      for (int k = 1; k <= 40; k++) begin
         tick();
         if (k <= 4)       exp = 1'b0;
         else if (k <= 36) exp = b[(k - 5) / 4];
         else              exp = 1'b1;
         check($sformatf("%s_k%0d", tag, k), {15'd0, txd}, {15'd0, exp});
      end
   endtask

   task automatic write(input logic [15:0] a, input logic [15:0] d, input logic [1:0] en);
      dwrite_addr = a;
      dwrite_data = d;
      dwrite_en   = en;
      tick();
      dwrite_en   = 2'b00;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset       = 1'b1;
      dwrite_addr = '0;
      dwrite_data = '0;
      dwrite_en   = 2'b00;
      dread_addr  = 16'hff00;
      tick();
      tick();
      reset = 1'b0;
      tick();
      check("rst_txd", {15'd0, txd}, 16'd1);
      check("rst_busy", {15'd0, busy}, 16'd0);
      check("rst_ovf", {15'd0, overflow}, 16'd0);
      check("rst_status", status_data, 16'h0002);
      check("rst_sel", {15'd0, status_sel}, 16'd1);
      dread_addr = 16'hff01;
      #1;
      check("sel_ff01", {15'd0, status_sel}, 16'd1);
      dread_addr = 16'hff02;
      #1;
      check("sel_ff02", {15'd0, status_sel}, 16'd0);
      check("status_unsel", status_data, 16'h0000);
      dread_addr = 16'hff00;

      // Single byte, low lane
      write(16'hff00, 16'h0055, 2'b01);
      check("p55_status", status_data, 16'h0104);
      check("p55_txd_idle", {15'd0, txd}, 16'd1);
      check_frame(8'h55, "f55");
      check("f55_busy_stop", {15'd0, busy}, 16'd1);
      tick();
      check("f55_busy_fall", {15'd0, busy}, 16'd0);

      // High lane at BASE_ADDR-1
      write(16'hfeff, 16'h4100, 2'b10);
      check("p41_status", status_data, 16'h0104);
      check_frame(8'h41, "f41");
      tick();
      check("f41_busy_fall", {15'd0, busy}, 16'd0);

      // Writes that must not push
      write(16'hff02, 16'h0055, 2'b01);
      check("nopush_ff02", status_data, 16'h0002);
      write(16'hff00, 16'h0055, 2'b10);
      check("nopush_hi", status_data, 16'h0002);
      tick();
      check("nopush_txd", {15'd0, txd}, 16'd1);

      // Burst of 10 with overflow, then clear handling while still full
      fork
         begin
            for (int i = 0; i < 10; i++) begin
               write(16'hff00, {8'h00, burst[i]}, 2'b01);
            end
            check("burst_ovf", {15'd0, overflow}, 16'd1);
            check("burst_status", status_data, 16'h080D);
            write(16'hff00, 16'h0177, 2'b11);
            check("setwins_ovf", {15'd0, overflow}, 16'd1);
            check("setwins_status", status_data, 16'h080D);
            write(16'hff00, 16'h0100, 2'b10);
            check("clr_ovf", {15'd0, overflow}, 16'd0);
            check("clr_status", status_data, 16'h0805);
         end
         begin
            tick();
            for (int i = 0; i < 9; i++) begin
               check_frame(burst[i], $sformatf("burst%0d", i));
            end
         end
      join
      tick();
      check("burst_busy_fall", {15'd0, busy}, 16'd0);
      check("burst_status_end", status_data, 16'h0002);

      // Reset during DATA bit 3 with one byte still queued
      write(16'hff00, 16'h00A5, 2'b01);
      write(16'hff00, 16'h0066, 2'b01);
      for (int i = 0; i < 17; i++) tick();
      check("mid_bit3", {15'd0, txd}, 16'd0);
      check("mid_status", status_data, 16'h0104);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("abort_txd", {15'd0, txd}, 16'd1);
      check("abort_busy", {15'd0, busy}, 16'd0);
      check("abort_status", status_data, 16'h0002);
      tick();
      check("abort_idle_txd", {15'd0, txd}, 16'd1);
      write(16'hff00, 16'h003C, 2'b01);
      check_frame(8'h3C, "f3c");
      tick();
      check("f3c_busy_fall", {15'd0, busy}, 16'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
